// File: rtl/urv_mem_arb_pkg.sv
// Shared configuration and memory-bus types for the uRV memory arbiter.
// urv_cfg holds the bus widths and urv_typedef holds the request/response types.

package urv_cfg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;
endpackage

package urv_typedef;
    import urv_cfg::*;

    typedef enum logic [0:0] {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_t;

    typedef struct packed {
        mem_req_type_t           req_type;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   wdata;
        logic [MEM_STRB_W-1:0]   wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0]   rdata;
        logic                    err;
    } mem_resp_t;
endpackage

// File: rtl/urv_mem_arb_if.sv
// Bus bundle between the requesting channels, the arbiter and downstream memory.
// slave is the arbiter's view; master is the view of the surrounding environment.

interface urv_mem_arb_if #(
    parameter int NUM_CH = 2
) ();
    import urv_typedef::*;

    logic [NUM_CH-1:0]           ch_req_valid;
    logic [NUM_CH-1:0]           ch_req_ready;
    mem_req_t [NUM_CH-1:0]       ch_req;
    logic [NUM_CH-1:0]           ch_resp_valid;
    logic [NUM_CH-1:0]           ch_resp_ready;
    mem_resp_t                   ch_resp;
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    mem_req_t                    mem_req;
    logic                        mem_resp_valid;
    logic                        mem_resp_ready;
    mem_resp_t                   mem_resp;

    modport slave (
        input  ch_req_valid,
        output ch_req_ready,
        input  ch_req,
        output ch_resp_valid,
        input  ch_resp_ready,
        output ch_resp,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req,
        input  mem_resp_valid,
        output mem_resp_ready,
        input  mem_resp
    );

    modport master (
        output ch_req_valid,
        input  ch_req_ready,
        output ch_req,
        input  ch_resp_valid,
        output ch_resp_ready,
        input  ch_resp,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req,
        output mem_resp_valid,
        input  mem_resp_ready,
        output mem_resp
    );
endinterface

// File: rtl/urv_ostd_fifo.sv
// Order FIFO of channel indices for requests still awaiting a response.
// DEPTH is a power of two so the pointers wrap naturally; the count is one bit wider.

module urv_ostd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; a full FIFO refuses pushes even while popping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end
endmodule

// File: rtl/urv_mem_arb.sv
// Round-robin arbiter merging NUM_CH memory request channels onto one downstream port.
// Requests pass through a one-entry output register; responses come back in order
// and are routed to the channel recorded at the head of the order FIFO.

module urv_mem_arb
    import urv_typedef::*;
#(
    parameter int NUM_CH     = 2,
    parameter int OSTD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    urv_mem_arb_if.slave  bus,
    output logic          err_unexp_resp
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] prio_r;
    logic [CH_W-1:0] grant_s;
    logic [CH_W-1:0] idx_s;
    logic            grant_found_s;
    logic            can_accept_s;
    logic            accept_s;
    logic            out_valid_r;
    mem_req_t        out_req_r;

    logic            fifo_pop_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [CH_W-1:0] fifo_head_s;

    // Pick the first valid channel at or after the priority pointer.
    always_comb begin
        grant_s       = {CH_W{1'b0}};
        grant_found_s = 1'b0;
        idx_s         = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = CH_W'((int'(prio_r) + k) % NUM_CH);
            if (!grant_found_s && bus.ch_req_valid[idx_s]) begin
                grant_s       = idx_s;
                grant_found_s = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Accept only when the output slot frees this cycle and the FIFO has room;
    // a pop in the same cycle does not count as room.
    assign can_accept_s = (!out_valid_r || bus.mem_req_ready) && !fifo_full_s && !rst;
    assign accept_s     = grant_found_s && can_accept_s;

    // Ready is one-hot on the granted channel and only when it will be accepted.
    always_comb begin
        bus.ch_req_ready = {NUM_CH{1'b0}};
        if (accept_s) begin
            bus.ch_req_ready[grant_s] = 1'b1;
        end else begin
            bus.ch_req_ready = {NUM_CH{1'b0}};
        end
    end

    // Output register and priority pointer; payload held until downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r      <= {CH_W{1'b0}};
            out_valid_r <= 1'b0;
            out_req_r   <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_req_r   <= bus.ch_req[grant_s];
            if (grant_s == CH_W'(NUM_CH - 1)) begin
                prio_r <= {CH_W{1'b0}};
            end else begin
                prio_r <= grant_s + CH_W'(1);
            end
        end else if (bus.mem_req_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.mem_req_valid = out_valid_r;
    assign bus.mem_req       = out_req_r;

    // Route the downstream response to the head channel; with nothing outstanding
    // the response is swallowed and routed nowhere.
    always_comb begin
        bus.ch_resp       = bus.mem_resp;
        bus.ch_resp_valid = {NUM_CH{1'b0}};
        if (fifo_empty_s) begin
            bus.mem_resp_ready = 1'b1;
        end else begin
            bus.mem_resp_ready             = bus.ch_resp_ready[fifo_head_s];
            bus.ch_resp_valid[fifo_head_s] = bus.mem_resp_valid;
        end
    end

    assign fifo_pop_s = !fifo_empty_s && bus.mem_resp_valid && bus.ch_resp_ready[fifo_head_s];

    // Sticky flag for a response that arrives with no request outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexp_resp <= 1'b0;
        end else if (bus.mem_resp_valid && fifo_empty_s) begin
            err_unexp_resp <= 1'b1;
        end
    end

    urv_ostd_fifo #(
        .DEPTH (OSTD_DEPTH),
        .WIDTH (CH_W)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .din   (grant_s),
        .pop   (fifo_pop_s),
        .dout  (fifo_head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );
endmodule

// File: tb/tb_urv_mem_arb.sv
// Directed bench for urv_mem_arb with two channels and four outstanding entries.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_urv_mem_arb;
    import urv_typedef::*;

    localparam int NUM_CH     = 2;
    localparam int OSTD_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_unexp_resp;
    int   n_checks = 0;
    int   n_fails  = 0;

    urv_mem_arb_if #(.NUM_CH(NUM_CH)) bus ();

    urv_mem_arb #(.NUM_CH(NUM_CH), .OSTD_DEPTH(OSTD_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    function automatic mem_req_t mk_req(input logic wr, input logic [31:0] addr);
        mem_req_t r;
        r.req_type = wr ? MEM_WRITE : MEM_READ;
        r.addr     = addr;
        r.wdata    = ~addr;
        r.wstrb    = 4'hF;
        return r;
    endfunction

    // Address of the j-th request in the alternating round-robin stream.
    function automatic logic [31:0] rr_addr(input int j);
        return ((j % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100) + 32'(4 * (j / 2));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ch_req_valid   = 2'b11;
        bus.ch_req[0]      = mk_req(1'b0, 32'h0000_0100);
        bus.ch_req[1]      = mk_req(1'b1, 32'h0000_0200);
        bus.ch_resp_ready  = 2'b00;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.ch_req_ready !== 2'b00) begin n_fails++; $display("FAIL rst_ch_req_ready got %b want 00", bus.ch_req_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fails++; $display("FAIL rst_mem_req_valid got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.ch_resp_valid !== 2'b00) begin n_fails++; $display("FAIL rst_ch_resp_valid got %b want 00", bus.ch_resp_valid); end
        n_checks++; if (err_unexp_resp !== 1'b0) begin n_fails++; $display("FAIL rst_err got %b want 0", err_unexp_resp); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ch_req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (bus.mem_resp_ready !== 1'b1) begin n_fails++; $display("FAIL rst_mem_resp_ready got %b want 1", bus.mem_resp_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fails++; $display("FAIL post_rst_mem_req_valid got %b want 0", bus.mem_req_valid); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_ready;
        logic [1:0]    exp_resp;
        logic          exp_mvalid;
        mem_req_type_t exp_type;
        for (int i = 0; i < 8; i++) begin
            bus.ch_req_valid   = (i < 6) ? 2'b11 : 2'b00;
            bus.ch_req[0]      = mk_req(1'b0, 32'h0000_0100 + 32'(4 * ((i + 1) / 2)));
            bus.ch_req[1]      = mk_req(1'b1, 32'h0000_0200 + 32'(4 * (i / 2)));
            bus.mem_req_ready  = 1'b1;
            bus.ch_resp_ready  = 2'b11;
            bus.mem_resp_valid = (i >= 2);
            bus.mem_resp.rdata = rr_addr(i - 2) ^ 32'hA5A5_0000;
            bus.mem_resp.err   = 1'b0;
            @(negedge clk);
            exp_ready  = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            exp_mvalid = (i >= 1) && (i <= 6);
            exp_resp   = (i < 2) ? 2'b00 : (((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
            exp_type   = ((i - 1) % 2 == 1) ? MEM_WRITE : MEM_READ;
            n_checks++; if (bus.ch_req_ready !== exp_ready) begin n_fails++; $display("FAIL rr_grant cyc%0d got %b want %b", i, bus.ch_req_ready, exp_ready); end
            n_checks++; if (bus.mem_req_valid !== exp_mvalid) begin n_fails++; $display("FAIL rr_mem_req_valid cyc%0d got %b want %b", i, bus.mem_req_valid, exp_mvalid); end
            if (exp_mvalid) begin
                n_checks++; if (bus.mem_req.addr !== rr_addr(i - 1)) begin n_fails++; $display("FAIL rr_mem_req_addr cyc%0d got %h want %h", i, bus.mem_req.addr, rr_addr(i - 1)); end
                n_checks++; if (bus.mem_req.req_type !== exp_type) begin n_fails++; $display("FAIL rr_mem_req_type cyc%0d got %b want %b", i, bus.mem_req.req_type, exp_type); end
            end
            n_checks++; if (bus.ch_resp_valid !== exp_resp) begin n_fails++; $display("FAIL rr_resp_route cyc%0d got %b want %b", i, bus.ch_resp_valid, exp_resp); end
            if (i >= 2) begin
                n_checks++; if (bus.ch_resp.rdata !== (rr_addr(i - 2) ^ 32'hA5A5_0000)) begin n_fails++; $display("FAIL rr_resp_data cyc%0d got %h want %h", i, bus.ch_resp.rdata, rr_addr(i - 2) ^ 32'hA5A5_0000); end
            end
            next_cycle();
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_stall();
        int accepts = 0;
        bus.ch_req_valid  = 2'b01;
        bus.ch_req[0]     = mk_req(1'b1, 32'h0000_0300);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.ch_req_ready !== 2'b01) begin n_fails++; $display("FAIL stall_first_accept got %b want 01", bus.ch_req_ready); end
        next_cycle();
        bus.ch_req[0] = mk_req(1'b0, 32'h0000_0304);
        for (int i = 1; i <= 6; i++) begin
            bus.mem_req_ready = (i == 6);
            @(negedge clk);
            if (bus.ch_req_ready[0] && bus.ch_req_valid[0]) accepts++;
            n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req.addr !== 32'h0000_0300) begin n_fails++; $display("FAIL stall_hold cyc%0d got v=%b a=%h want v=1 a=00000300", i, bus.mem_req_valid, bus.mem_req.addr); end
            if (i < 6) begin
                n_checks++; if (bus.ch_req_ready !== 2'b00) begin n_fails++; $display("FAIL stall_ready_low cyc%0d got %b want 00", i, bus.ch_req_ready); end
            end
            next_cycle();
        end
        n_checks++; if (accepts !== 1) begin n_fails++; $display("FAIL stall_accept_count got %0d want 1", accepts); end
        bus.ch_req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req.addr !== 32'h0000_0304) begin n_fails++; $display("FAIL stall_second_req got v=%b a=%h want v=1 a=00000304", bus.mem_req_valid, bus.mem_req.addr); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fails++; $display("FAIL stall_drained got %b want 0", bus.mem_req_valid); end
        next_cycle();
    endtask

    task automatic test_resp_backpressure();
        for (int i = 0; i < 5; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp.rdata = 32'h0000_C000 + 32'(i);
            bus.ch_resp_ready  = (i < 3) ? 2'b00 : 2'b01;
            @(negedge clk);
            n_checks++; if (bus.mem_resp_ready !== (i >= 3)) begin n_fails++; $display("FAIL bp_mem_resp_ready cyc%0d got %b want %b", i, bus.mem_resp_ready, (i >= 3)); end
            n_checks++; if (bus.ch_resp_valid !== 2'b01) begin n_fails++; $display("FAIL bp_head_route cyc%0d got %b want 01", i, bus.ch_resp_valid); end
            next_cycle();
        end
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_resp_ready !== 1'b1) begin n_fails++; $display("FAIL bp_empty_ready got %b want 1", bus.mem_resp_ready); end
        n_checks++; if (err_unexp_resp !== 1'b0) begin n_fails++; $display("FAIL bp_err got %b want 0", err_unexp_resp); end
        next_cycle();
    endtask

    task automatic test_ostd_full();
        logic [1:0] exp_ready;
        bus.ch_req_valid  = 2'b01;
        bus.mem_req_ready = 1'b1;
        bus.ch_resp_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            bus.ch_req[0]      = mk_req(1'b0, 32'h0000_0400 + 32'(4 * i));
            bus.mem_resp_valid = (i == 6);
            @(negedge clk);
            exp_ready = (i < 4 || i == 7) ? 2'b01 : 2'b00;
            n_checks++; if (bus.ch_req_ready !== exp_ready) begin n_fails++; $display("FAIL full_ready cyc%0d got %b want %b", i, bus.ch_req_ready, exp_ready); end
            if (i == 5) begin
                n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fails++; $display("FAIL full_out_empty got %b want 0", bus.mem_req_valid); end
            end
            if (i == 6) begin
                n_checks++; if (bus.ch_resp_valid !== 2'b01) begin n_fails++; $display("FAIL full_pop_route got %b want 01", bus.ch_resp_valid); end
            end
            next_cycle();
        end
        bus.ch_req_valid   = 2'b00;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus.ch_resp_valid !== 2'b01) begin n_fails++; $display("FAIL full_drain cyc%0d got %b want 01", i, bus.ch_resp_valid); end
            next_cycle();
        end
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (err_unexp_resp !== 1'b0) begin n_fails++; $display("FAIL full_err got %b want 0", err_unexp_resp); end
        next_cycle();
    endtask

    task automatic test_unexpected_resp();
        bus.mem_resp_valid = 1'b1;
        bus.ch_resp_ready  = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.mem_resp_ready !== 1'b1) begin n_fails++; $display("FAIL unexp_ready got %b want 1", bus.mem_resp_ready); end
        n_checks++; if (bus.ch_resp_valid !== 2'b00) begin n_fails++; $display("FAIL unexp_route got %b want 00", bus.ch_resp_valid); end
        n_checks++; if (err_unexp_resp !== 1'b0) begin n_fails++; $display("FAIL unexp_err_early got %b want 0", err_unexp_resp); end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (err_unexp_resp !== 1'b1) begin n_fails++; $display("FAIL unexp_err_sticky cyc%0d got %b want 1", i, err_unexp_resp); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        bus.ch_req_valid  = 2'b11;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.ch_req_ready !== 2'b10) begin n_fails++; $display("FAIL mid_grant0 got %b want 10", bus.ch_req_ready); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.ch_req_ready !== 2'b01) begin n_fails++; $display("FAIL mid_grant1 got %b want 01", bus.ch_req_ready); end
        next_cycle();
        bus.ch_req_valid  = 2'b00;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_fails++; $display("FAIL mid_pending got %b want 1", bus.mem_req_valid); end
        #1;
        rst = 1'b1;
        bus.ch_req_valid = 2'b11;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fails++; $display("FAIL mid_rst_mem_req_valid got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.ch_req_ready !== 2'b00) begin n_fails++; $display("FAIL mid_rst_ready got %b want 00", bus.ch_req_ready); end
        n_checks++; if (err_unexp_resp !== 1'b0) begin n_fails++; $display("FAIL mid_rst_err got %b want 0", err_unexp_resp); end
        n_checks++; if (bus.mem_resp_ready !== 1'b1) begin n_fails++; $display("FAIL mid_rst_fifo_empty got %b want 1", bus.mem_resp_ready); end
        next_cycle();
        rst = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.ch_req_ready !== 2'b01) begin n_fails++; $display("FAIL mid_prio_reset got %b want 01", bus.ch_req_ready); end
        n_checks++; if (bus.ch_resp_valid !== 2'b00) begin n_fails++; $display("FAIL mid_stale_route got %b want 00", bus.ch_resp_valid); end
        next_cycle();
        bus.ch_req_valid   = 2'b00;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (err_unexp_resp !== 1'b1) begin n_fails++; $display("FAIL mid_stale_err got %b want 1", err_unexp_resp); end
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_fails++; $display("FAIL mid_new_req got %b want 1", bus.mem_req_valid); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_resp_backpressure();
        test_ostd_full();
        test_unexpected_resp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/urv_mem_arb.md
URV_MEM_ARB -- requirements
Module: urv_mem_arb

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting channels (legal 2..8).
REQ-002 Parameter OSTD_DEPTH, default 4, maximum outstanding requests (power of 2, legal 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_req_valid  input  NUM_CH  per-channel request valid.
REQ-006 ch_req_ready  output  NUM_CH  per-channel request accepted.
REQ-007 ch_req  input  NUM_CH x mem_req_t  per-channel request payload.
REQ-008 ch_resp_valid  output  NUM_CH  per-channel response valid.
REQ-009 ch_resp_ready  input  NUM_CH  per-channel response accepted.
REQ-010 ch_resp  output  mem_resp_t  response payload, shared by all channels.
REQ-011 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-012 mem_req  output  mem_req_t  downstream request payload.
REQ-013 mem_resp_valid / mem_resp_ready  input / output  1 / 1  downstream response handshake.
REQ-014 mem_resp  input  mem_resp_t  downstream response payload.
REQ-015 err_unexp_resp  output  1  sticky flag: response arrived with no outstanding request.

Function
REQ-016 Every request, read or write, SHALL produce exactly one downstream response; responses return in request order.
REQ-017 Arbitration SHALL be round-robin: a priority pointer starts at 0 and, after a grant to channel i, moves to (i+1) mod NUM_CH.
REQ-018 ch_req_ready[i] SHALL be high only for the granted channel, only when the output register is empty or draining (mem_req_ready high) and the outstanding count is below OSTD_DEPTH.
REQ-019 An accepted request SHALL be held in a one-entry output register; mem_req_valid rises on the cycle after acceptance (latency 1).
REQ-020 mem_req and mem_req_valid SHALL stay stable until mem_req_ready is sampled high; a back-to-back accept in the drain cycle is permitted (full throughput).
REQ-021 On acceptance, the granted channel index SHALL be pushed into an order FIFO of depth OSTD_DEPTH; the push pointer wraps modulo OSTD_DEPTH.
REQ-022 Head-of-FIFO channel h SHALL see ch_resp_valid[h] = mem_resp_valid, ch_resp = mem_resp, mem_resp_ready = ch_resp_ready[h]; all other ch_resp_valid bits stay low.
REQ-023 A response handshake SHALL pop the FIFO; the pop pointer wraps modulo OSTD_DEPTH.
REQ-024 When the count equals OSTD_DEPTH, a pop in the same cycle SHALL NOT enable a push; the push is granted on the following cycle.
REQ-025 Simultaneous push and pop at a count below full SHALL leave the count unchanged.
REQ-026 When the FIFO is empty, mem_resp_ready SHALL be high; a response then sets err_unexp_resp, is dropped, and is routed to no channel.
REQ-027 err_unexp_resp SHALL clear only on reset.

Reset
REQ-028 On rst high, the following SHALL be cleared asynchronously: mem_req_valid=0, ch_req_ready=0, ch_resp_valid=0, priority pointer=0, FIFO pointers and count=0, err_unexp_resp=0.
REQ-029 Reset mid-transaction SHALL discard the buffered request and all outstanding entries; responses arriving after reset set err_unexp_resp.
REQ-030 Outputs SHALL be driven from reset values on the first edge after rst deasserts.

Structure
REQ-031 mem_req_t, mem_resp_t and mem_req_type_t SHALL be imported from urv_typedef; MEM_* widths SHALL be imported from urv_cfg.
REQ-032 The order FIFO SHALL be a sub-module, urv_ostd_fifo, parametrised by depth and entry width $clog2(NUM_CH).
REQ-033 The arbiter SHALL contain no memory-mapped or CSR state.

Verification
REQ-034 Both channels valid continuously, mem_req_ready=1, immediate responses -> grants alternate 0,1,0,1; each channel receives its own responses in order.
REQ-035 Ch0 only, mem_req_ready=0 for 5 cycles -> mem_req is stable for all 5 cycles, ch_req_ready[0]=0, and there is exactly one accept after ready returns.
REQ-036 OSTD_DEPTH=4, 4 requests issued, no responses -> 5th request stalls; pop and push in the same cycle -> push is granted on the next cycle.
REQ-037 Responses with ch_resp_ready[h]=0 for 3 cycles -> mem_resp_ready=0, FIFO head is unchanged, and there is no pop.
REQ-038 mem_resp_valid=1 with empty FIFO -> err_unexp_resp=1 the next cycle and stays set until rst.
REQ-039 rst asserted with 2 outstanding requests and mem_req_valid=1 -> all outputs go to reset values immediately and the count is 0.
